// File: rtl/img_pkg.sv
// img_pkg: shared geometry defaults and the line-feeder state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package img_pkg;

    // Default frame geometry, shared with imageProcessTop and its bench.
    localparam int IMG_W = 512;
    localparam int IMG_H = 512;

    // Line-feeder FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SEND    = 3'd3,
        ST_FINISH  = 3'd4
    } feeder_state_t;

    // Counter width helper: never returns less than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/feeder_skid_buf.sv
// feeder_skid_buf: 2-entry 8-bit skid FIFO between frame-memory read data and the pixel port.
// Latency: a pushed byte appears on out_vld/out_dat the cycle after the push.
// Backpressure: out_dat is held stable while out_rdy is low; the caller never pushes when full.
module feeder_skid_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       out_rdy,
    output logic       out_vld,
    output logic [7:0] out_dat,
    output logic [1:0] count
);

    // head is the output register; tail only fills while the head is stalled.
    logic [7:0] head;
    logic [7:0] tail;
    logic [1:0] cnt;
    logic       vld;
    logic       pop;

    assign pop     = vld && out_rdy;
    assign out_vld = vld;
    assign out_dat = head;
    assign count   = cnt;

    // Occupancy update: head always holds the oldest byte, tail the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= 8'd0;
            tail <= 8'd0;
            cnt  <= 2'd0;
            vld  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        head <= push_dat;
                        cnt  <= 2'd1;
                        vld  <= 1'b1;
                    end else if (cnt == 2'd1) begin
                        tail <= push_dat;
                        cnt  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt == 2'd2) begin
                        head <= tail;
                        cnt  <= 2'd1;
                    end else begin
                        cnt <= 2'd0;
                        vld <= 1'b0;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        head <= tail;
                        tail <= push_dat;
                    end else begin
                        head <= push_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/image_line_feeder.sv
// image_line_feeder: streams frame-memory lines (plus trailing zero lines) into the pixel port.
// Latency: first o_data_valid 2 cycles after entering PREFILL or SEND; 1 pixel/cycle with ready high.
// Backpressure: o_data/o_data_valid held until i_data_ready; reads stop while the skid buffer is full.
module image_line_feeder
    import img_pkg::*;
#(
    parameter int IMG_WIDTH     = IMG_W,
    parameter int IMG_HEIGHT    = IMG_H,
    parameter int PREFILL_LINES = 4,
    parameter int PAD_LINES     = 2,
    parameter int ADDR_W        = 18
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_data_valid,
    output logic [7:0]        o_data,
    input  logic              i_data_ready,
    input  logic              i_intr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    localparam int TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
    localparam int BURST_MAX   = PREFILL_LINES * IMG_WIDTH;
    localparam int COL_W       = clog2_min1(IMG_WIDTH);
    localparam int LINE_W      = clog2_min1(TOTAL_LINES);
    localparam int BURST_W     = clog2_min1(BURST_MAX + 1);

    localparam logic [COL_W-1:0]   LAST_COL      = COL_W'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0]  LAST_LINE     = LINE_W'(TOTAL_LINES - 1);
    localparam logic [LINE_W-1:0]  LAST_PREFILL  = LINE_W'(PREFILL_LINES - 1);
    localparam logic [LINE_W-1:0]  FIRST_PAD     = LINE_W'(IMG_HEIGHT);
    localparam logic [BURST_W-1:0] PREFILL_BURST = BURST_W'(BURST_MAX);
    localparam logic [BURST_W-1:0] LINE_BURST    = BURST_W'(IMG_WIDTH);

    feeder_state_t state;
    feeder_state_t state_nx;

    logic                intr_r1;
    logic                intr_r2;
    logic                credit;
    logic                pending;
    logic                overrun;

    logic [COL_W-1:0]    col;
    logic [LINE_W-1:0]   line;
    logic [BURST_W-1:0]  burst_left;
    logic [ADDR_W-1:0]   addr;

    logic                streaming;
    logic                pad_line;
    logic                issue;
    logic                issue_d;
    logic                pad_d;
    logic [2:0]          occ_sum;
    logic                beat;
    logic                line_end;
    logic                start_ok;
    logic                busy;
    logic                done;

    logic                skid_vld;
    logic [7:0]          skid_dat;
    logic [1:0]          skid_count;
    logic [7:0]          push_dat;

    assign credit   = intr_r1 && !intr_r2;
    assign start_ok = (state == ST_IDLE) && i_start;
    assign beat     = skid_vld && i_data_ready;
    assign line_end = beat && (col == LAST_COL);
    assign pad_line = (state == ST_SEND) && (line >= FIRST_PAD);

    // Pad lines travel the same pipeline as memory reads but carry zero.
    assign push_dat = pad_d ? 8'd0 : i_rd_data;

    assign o_rd_addr    = addr;
    assign o_data_valid = skid_vld;
    assign o_data       = skid_dat;
    assign o_overrun    = overrun;
    assign o_busy       = busy;
    assign o_done       = done;

    // State register.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs; a state exits only on acceptance of its last pixel.
    always_comb begin
        state_nx  = state;
        streaming = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (i_start) begin
                    state_nx = ST_PREFILL;
                end
            end
            ST_PREFILL: begin
                streaming = 1'b1;
                if (line_end && (line == LAST_PREFILL)) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pending || credit) begin
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                streaming = 1'b1;
                if (line_end) begin
                    state_nx = (line == LAST_LINE) ? ST_FINISH : ST_WAIT;
                end
            end
            ST_FINISH: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Read issue: the skid buffer can take one more byte if its occupancy plus the byte in
    // flight, minus the byte leaving this cycle, is below its depth. Counting the outgoing
    // byte is what keeps a full-rate stream going with ready held high.
    always_comb begin
        occ_sum = {1'b0, skid_count} + {2'b00, issue_d};
        issue   = streaming && (burst_left != '0) && (occ_sum < (3'd2 + {2'b00, beat}));
        o_rd_en = issue && !pad_line;
    end

    // Interrupt edge detect, 1-deep credit pending and sticky overrun.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            intr_r1 <= 1'b0;
            intr_r2 <= 1'b0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            intr_r1 <= i_intr;
            intr_r2 <= intr_r1;
            if (start_ok) begin
                pending <= 1'b0;
                overrun <= 1'b0;
            end else begin
                case (state)
                    // A stored credit is spent first; a fresh edge in the same cycle is kept.
                    ST_WAIT: pending <= pending && credit;
                    ST_PREFILL, ST_SEND: begin
                        if (credit) begin
                            if (pending) begin
                                overrun <= 1'b1;
                            end else begin
                                pending <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Issue budget, read address and acceptance-side column/line counters.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            col        <= '0;
            line       <= '0;
            burst_left <= '0;
            addr       <= '0;
        end else if (start_ok) begin
            col        <= '0;
            line       <= '0;
            burst_left <= PREFILL_BURST;
            addr       <= '0;
        end else begin
            if ((state == ST_WAIT) && (state_nx == ST_SEND)) begin
                burst_left <= LINE_BURST;
            end else if (issue) begin
                burst_left <= burst_left - 1'b1;
            end
            if (o_rd_en) begin
                addr <= addr + 1'b1;
            end
            if (beat) begin
                if (col == LAST_COL) begin
                    col  <= '0;
                    line <= (line == LAST_LINE) ? '0 : line + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Read-latency pipeline: marks which cycle's i_rd_data (or pad zero) enters the skid buffer.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            issue_d <= 1'b0;
            pad_d   <= 1'b0;
        end else begin
            issue_d <= issue;
            pad_d   <= pad_line;
        end
    end

    feeder_skid_buf u_skid (
        .clk      (axi_clk),
        .rst      (axi_reset),
        .push     (issue_d),
        .push_dat (push_dat),
        .out_rdy  (i_data_ready),
        .out_vld  (skid_vld),
        .out_dat  (skid_dat),
        .count    (skid_count)
    );

endmodule

// File: tb/tb_image_line_feeder.sv
// tb_image_line_feeder: drives frames through image_line_feeder and compares the pixel stream.
// Latency: n/a.
// Backpressure: random ready in parts of the run.
module tb_image_line_feeder;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int PF  = 4;
    localparam int PAD = 2;
    localparam int AW  = 8;

    logic          axi_clk = 1'b0;
    logic          axi_reset;
    logic          i_start;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [7:0]    i_rd_data;
    logic          o_data_valid;
    logic [7:0]    o_data;
    logic          i_data_ready;
    logic          i_intr;
    logic          o_busy;
    logic          o_done;
    logic          o_overrun;

    image_line_feeder #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .PREFILL_LINES (PF),
        .PAD_LINES     (PAD),
        .ADDR_W        (AW)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset    (axi_reset),
        .i_start      (i_start),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .i_data_ready (i_data_ready),
        .i_intr       (i_intr),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overrun    (o_overrun)
    );

    always #5 axi_clk = ~axi_clk;

    // Frame memory: content equals the low address byte, one cycle read latency.
    always @(posedge axi_clk) begin
        if (o_rd_en) begin
            i_rd_data <= o_rd_addr[7:0];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    int   beats[$];
    int   beat_cyc[$];
    int   cyc        = 0;
    int   done_cnt   = 0;
    int   done_cyc   = 0;
    int   stall_err  = 0;
    int   addr_err   = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'd0;

    int   done_base  = 0;
    bit   rand_ready = 1'b0;

    // Monitor on the falling edge: accepted beats, stall stability, done pulses, address range.
    always @(negedge axi_clk) begin
        if (axi_reset) begin
            prev_stall <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (o_data_valid && i_data_ready) begin
                beats.push_back(int'(o_data));
                beat_cyc.push_back(cyc);
            end
            if (prev_stall && (!o_data_valid || (o_data != prev_dat))) begin
                stall_err <= stall_err + 1;
            end
            prev_stall <= o_data_valid && !i_data_ready;
            prev_dat   <= o_data;
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (o_rd_en && (int'(o_rd_addr) >= W * H)) begin
                addr_err <= addr_err + 1;
            end
        end
    end

    task automatic chk(input string tag, input int seen, input int want);
        n_tests++;
        if (seen != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, seen, want);
        end
    endtask

    // Reference pixel at stream position idx: memory lines carry their linear address, pad lines zero.
    function automatic int exp_pix(input int idx);
        if ((idx / W) < H) begin
            return idx % 256;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
        if (rand_ready) begin
            i_data_ready = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic start_frame();
        done_base = done_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        tick();
        tick();
        i_intr = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((beats.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        chk(tag, beats.size(), n);
    endtask

    task automatic wait_quiet();
        int k;
        int q;
        k = 0;
        q = 0;
        while ((q < 4) && (k < 400)) begin
            tick();
            q = o_data_valid ? 0 : q + 1;
            k++;
        end
    endtask

    task automatic check_range(input string tag, input int lo, input int hi);
        int v;
        for (int i = lo; i < hi; i++) begin
            v = (i < beats.size()) ? beats[i] : -1;
            chk($sformatf("%s[%0d]", tag, i), v, exp_pix(i));
        end
    endtask

    // Sends the remaining lines one interrupt at a time and checks the frame completes once.
    task automatic finish_frame(input int first_line, input string tag);
        int k;
        for (int l = first_line; l < H + PAD; l++) begin
            pulse_intr();
            wait_beats((l + 1) * W, 400, $sformatf("%s_line%0d_cnt", tag, l));
            wait_quiet();
        end
        check_range(tag, first_line * W, (H + PAD) * W);
        k = 0;
        while (o_busy && (k < 50)) begin
            tick();
            k++;
        end
        chk({tag, "_busy_clear"}, int'(o_busy), 0);
        chk({tag, "_done_once"}, done_cnt - done_base, 1);
        chk({tag, "_no_extra_beats"}, beats.size(), (H + PAD) * W);
    endtask

    task automatic clear_capture();
        beats.delete();
        beat_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        axi_reset    = 1'b1;
        i_start      = 1'b0;
        i_intr       = 1'b0;
        i_data_ready = 1'b1;
        tick();
        tick();
        axi_reset = 1'b0;
        tick();

        // 1: reset state, then full-rate prefill
        chk("rst_valid",   int'(o_data_valid), 0);
        chk("rst_rd_en",   int'(o_rd_en), 0);
        chk("rst_rd_addr", int'(o_rd_addr), 0);
        chk("rst_data",    int'(o_data), 0);
        chk("rst_busy",    int'(o_busy), 0);
        chk("rst_done",    int'(o_done), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        clear_capture();
        start_frame();
        n = 0;
        while (!o_data_valid && (n < 10)) begin
            tick();
            n++;
        end
        chk("t1_first_valid_lat", n, 2);
        wait_beats(PF * W, 200, "t1_prefill_cnt");
        tick();
        tick();
        chk("t1_valid_after_prefill", int'(o_data_valid), 0);
        chk("t1_busy_after_prefill", int'(o_busy), 1);
        check_range("t1_prefill", 0, PF * W);
        chk("t1_back_to_back", beat_cyc[PF * W - 1] - beat_cyc[0], PF * W - 1);

        // 2: one line per interrupt, then pad lines and done
        wait_quiet();
        finish_frame(PF, "t2");
        chk("t2_done_after_last", int'(done_cyc > beat_cyc[(H + PAD) * W - 1]), 1);

        // 3: random backpressure during prefill
        clear_capture();
        rand_ready = 1'b1;
        start_frame();
        wait_beats(PF * W, 600, "t3_prefill_cnt");
        check_range("t3_prefill", 0, PF * W);
        wait_quiet();
        finish_frame(PF, "t3");
        chk("t3_stall_stable", stall_err, 0);

        // 4: interrupt during prefill is held and served without another edge
        clear_capture();
        rand_ready   = 1'b0;
        i_data_ready = 1'b1;
        start_frame();
        wait_beats(10, 100, "t4_beat10");
        pulse_intr();
        wait_beats(PF * W, 100, "t4_prefill_cnt");
        wait_beats((PF + 1) * W, 100, "t4_line4_no_intr");
        check_range("t4_line4", PF * W, (PF + 1) * W);
        chk("t4_overrun", int'(o_overrun), 0);
        wait_quiet();
        finish_frame(PF + 1, "t4");

        // 5: two edges during one SEND line -> overrun, exactly one extra line
        clear_capture();
        start_frame();
        wait_beats(PF * W, 200, "t5_prefill_cnt");
        wait_quiet();
        i_data_ready = 1'b0;
        pulse_intr();
        n = 0;
        while (!o_data_valid && (n < 20)) begin
            tick();
            n++;
        end
        chk("t5_line4_valid", int'(o_data_valid), 1);
        pulse_intr();
        pulse_intr();
        tick();
        tick();
        rand_ready = 1'b1;
        wait_beats((PF + 2) * W, 600, "t5_two_lines_cnt");
        wait_quiet();
        repeat (20) tick();
        chk("t5_one_extra_line", beats.size(), (PF + 2) * W);
        chk("t5_overrun_set", int'(o_overrun), 1);
        check_range("t5_lines", PF * W, (PF + 2) * W);
        finish_frame(PF + 2, "t5");
        chk("t5_overrun_sticky", int'(o_overrun), 1);

        // 6: asynchronous reset mid-line, then a clean restart
        clear_capture();
        rand_ready   = 1'b0;
        i_data_ready = 1'b1;
        start_frame();
        tick();
        chk("t6_overrun_cleared", int'(o_overrun), 0);
        wait_beats(PF * W, 200, "t6_prefill_cnt");
        wait_quiet();
        pulse_intr();
        wait_beats(36, 100, "t6_beat35");
        #2;
        axi_reset = 1'b1;
        #1;
        chk("t6_async_valid",   int'(o_data_valid), 0);
        chk("t6_async_data",    int'(o_data), 0);
        chk("t6_async_rd_en",   int'(o_rd_en), 0);
        chk("t6_async_rd_addr", int'(o_rd_addr), 0);
        chk("t6_async_busy",    int'(o_busy), 0);
        chk("t6_async_done",    int'(o_done), 0);
        chk("t6_async_overrun", int'(o_overrun), 0);
        tick();
        tick();
        axi_reset = 1'b0;
        clear_capture();
        tick();
        chk("t6_no_done_on_reset", done_cnt - done_base, 0);
        start_frame();
        wait_beats(PF * W, 200, "t6_restart_cnt");
        check_range("t6_restart", 0, PF * W);
        wait_quiet();
        finish_frame(PF, "t6");

        chk("addr_in_range", addr_err, 0);
        chk("stall_stable_all", stall_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
